// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and constants for the systolic skew feeder
package systolic_pkg;

   localparam int ActBits = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/feeder_fifo.sv
// rtl/feeder_fifo.sv - beat FIFO with registered ready; pointers carry an extra wrap bit
module feeder_fifo #(
   parameter int Width = 8,
   parameter int Depth = 4
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             empty_o,
   output logic             ready_o
);

   localparam int PtrW = $clog2(Depth);

   logic [PtrW:0]    wr_q, wr_d;
   logic [PtrW:0]    rd_q, rd_d;
   logic             ready_q, ready_d;
   logic [Width-1:0] mem_q [Depth];

   assign wr_d = wr_q + (PtrW+1)'(push_i);
   assign rd_d = rd_q + (PtrW+1)'(pop_i);

   // Ready reflects the occupancy after this edge, so it never sees stall combinationally.
   assign ready_d = !((wr_d[PtrW] != rd_d[PtrW]) &&
                      (wr_d[PtrW-1:0] == rd_d[PtrW-1:0]));

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         ready_q <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         ready_q <= ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_q[PtrW-1:0]] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_q[PtrW-1:0]];
   assign empty_o = (wr_q == rd_q);
   assign ready_o = ready_q;

endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - FIFO-buffered diagonal skew feeder for a systolic array
// Optional: SYSTOLIC_FEEDER_ZERO_PAD_EN zeroes out_a on rows whose valid is low.
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int BitSize   = ActBits,
   parameter int Rows      = 4,
   parameter int FifoDepth = 4
) (
   input  logic                    clk,
   input  logic                    res_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [Rows*BitSize-1:0] in_data,
   input  logic                    in_last,
   input  logic                    stall,
   output logic [Rows-1:0]         out_valid,
   output logic [Rows*BitSize-1:0] out_a,
   output logic [Rows-1:0]         out_increment,
   output logic                    out_busy
);

   localparam int FifoW = Rows*BitSize + 1;
   localparam int CntW  = (Rows > 1) ? $clog2(Rows) : 1;
   localparam logic [CntW-1:0] DrainLast = CntW'((Rows > 1) ? Rows - 2 : 0);

   feeder_state_t state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic             fifo_ready, fifo_empty;
   logic [FifoW-1:0] fifo_rdata;
   logic             push, pop, pop_last;

   logic [Rows-1:0]              row_v, row_l, row_busy;
   logic [Rows-1:0][BitSize-1:0] row_a;

   assign push     = in_valid & fifo_ready;
   assign pop      = (state_q == STREAM) & ~fifo_empty & ~stall;
   assign pop_last = fifo_rdata[FifoW-1];

   feeder_fifo #(
      .Width (FifoW),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk     (clk),
      .res_n   (res_n),
      .push_i  (push),
      .wdata_i ({in_last, in_data}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .ready_o (fifo_ready)
   );

   // Row r owns stage 0 plus r delay stages; the whole array shifts only when not stalled.
   for (genvar r = 0; r < Rows; r++) begin : g_row
      logic [r:0]              v_q;
      logic [r:0]              l_q;
      logic [r:0][BitSize-1:0] a_q;

      always_ff @(posedge clk or negedge res_n) begin
         if (!res_n) begin
            v_q <= '0;
            l_q <= '0;
            a_q <= '0;
         end else if (!stall) begin
            v_q[0] <= pop;
            l_q[0] <= pop & pop_last;
            if (pop) begin
               a_q[0] <= fifo_rdata[r*BitSize +: BitSize];
            end
            for (int k = r; k > 0; k--) begin
               v_q[k] <= v_q[k-1];
               l_q[k] <= l_q[k-1];
               a_q[k] <= a_q[k-1];
            end
         end
      end

      assign row_v[r]    = v_q[r];
      assign row_l[r]    = l_q[r];
      assign row_a[r]    = a_q[r];
      assign row_busy[r] = |v_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (push || !fifo_empty) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (pop && pop_last) begin
               if (Rows > 1) begin
                  state_d = DRAIN;
                  cnt_d   = '0;
               end
            end else if (fifo_empty && !push && (row_busy == '0)) begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (!stall) begin
               if (cnt_q == DrainLast) begin
                  state_d = (push || !fifo_empty) ? STREAM : IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid     = row_v & {Rows{~stall}};
   assign out_increment = row_v & row_l & {Rows{~stall}};
   assign in_ready      = fifo_ready;
   assign out_busy      = (state_q != IDLE);

`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
   for (genvar r = 0; r < Rows; r++) begin : g_pad
      assign out_a[r*BitSize +: BitSize] = out_valid[r] ? row_a[r] : '0;
   end
`else
   assign out_a = row_a;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed self-checking bench for systolic_skew_feeder
module tb_systolic_skew_feeder;
   import systolic_pkg::*;

   logic        clk = 1'b0;
   logic        res_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        stall = 1'b0;
   logic [3:0]  out_valid;
   logic [31:0] out_a;
   logic [3:0]  out_increment;
   logic        out_busy;

   int n_cmp = 0;
   int n_err = 0;

   systolic_skew_feeder #(
      .BitSize   (8),
      .Rows      (4),
      .FifoDepth (4)
   ) dut (
      .clk           (clk),
      .res_n         (res_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .stall         (stall),
      .out_valid     (out_valid),
      .out_a         (out_a),
      .out_increment (out_increment),
      .out_busy      (out_busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && out_busy; i++) step();
      step();
      step();
      #1;
      n_cmp++;
      if (out_busy !== 1'b0) begin
         n_err++;
         $display("FAIL idle_timeout: out_busy=%b want 0", out_busy);
      end
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 4'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0000", out_valid); end
      n_cmp++; if (out_increment !== 4'b0) begin n_err++; $display("FAIL reset_out_inc: got %b want 0000", out_increment); end
      n_cmp++; if (out_a !== 32'h0) begin n_err++; $display("FAIL reset_out_a: got %h want 0", out_a); end
      n_cmp++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", out_busy); end
      step();
      step();
      res_n = 1'b1;
      step();
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_single();
      logic [3:0] ev;
      in_valid = 1'b1; in_data = 32'h04030201; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         step();
         #1;
         ev = (c <= 4) ? 4'(1 << (c - 1)) : 4'b0;
         n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL single_valid c%0d: got %b want %b", c, out_valid, ev); end
         n_cmp++; if (out_increment !== ev) begin n_err++; $display("FAIL single_inc c%0d: got %b want %b", c, out_increment, ev); end
         if (c <= 4) begin
            n_cmp++;
            if (out_a[(c-1)*8 +: 8] !== 8'(c)) begin
               n_err++; $display("FAIL single_data c%0d: got %h want %h", c, out_a[(c-1)*8 +: 8], 8'(c));
            end
         end
         if (c == 1) begin
            n_cmp++; if (dut.state_q !== DRAIN) begin n_err++; $display("FAIL single_drain: got %0d want %0d", dut.state_q, DRAIN); end
         end
         if (c == 4) begin
            n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL single_idle: got %0d want %0d", dut.state_q, IDLE); end
         end
      end
      wait_idle();
   endtask

   task automatic test_back_to_back();
      logic [3:0] ev, ei;
      int idx;
      for (int c = 0; c < 8; c++) begin
         in_valid = (c < 3);
         in_data  = {4{8'(8'h11 * (c + 1))}};
         in_last  = (c == 2);
         step();
         #1;
         ev = '0; ei = '0;
         for (int r = 0; r < 4; r++) begin
            idx = c - 1 - r;
            ev[r] = (idx >= 0) && (idx <= 2);
            ei[r] = (idx == 2);
            if (ev[r]) begin
               n_cmp++;
               if (out_a[r*8 +: 8] !== 8'(8'h11 * (idx + 1))) begin
                  n_err++; $display("FAIL b2b_data c%0d r%0d: got %h want %h", c, r, out_a[r*8 +: 8], 8'(8'h11 * (idx + 1)));
               end
            end
         end
         n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL b2b_valid c%0d: got %b want %b", c, out_valid, ev); end
         n_cmp++; if (out_increment !== ei) begin n_err++; $display("FAIL b2b_inc c%0d: got %b want %b", c, out_increment, ei); end
      end
      in_valid = 1'b0; in_last = 1'b0;
      wait_idle();
   endtask

   task automatic test_backpressure();
      int acc, got, bad_v;
      logic hs;
      acc = 0; got = 0; bad_v = 0;
      stall = 1'b1;
      for (int c = 0; c < 8; c++) begin
         in_valid = (acc < 6);
         in_data  = {4{8'(8'hA0 + acc)}};
         in_last  = (acc == 5);
         hs = in_valid && in_ready;
         step();
         if (hs) acc++;
         #1;
         if (out_valid !== 4'b0) bad_v++;
      end
      n_cmp++; if (acc !== 4) begin n_err++; $display("FAIL bp_accepted: got %0d want 4", acc); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
      n_cmp++; if (bad_v !== 0) begin n_err++; $display("FAIL bp_valid_during_stall: got %0d cycles want 0", bad_v); end
      stall = 1'b0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         in_valid = (acc < 6);
         in_data  = {4{8'(8'hA0 + acc)}};
         in_last  = (acc == 5);
         hs = in_valid && in_ready;
         step();
         if (hs) acc++;
         #1;
         if (out_valid[0]) begin
            n_cmp++;
            if (out_a[7:0] !== 8'(8'hA0 + got)) begin
               n_err++; $display("FAIL bp_order beat%0d: got %h want %h", got, out_a[7:0], 8'(8'hA0 + got));
            end
            n_cmp++;
            if (out_increment[0] !== (got == 5)) begin
               n_err++; $display("FAIL bp_inc beat%0d: got %b want %b", got, out_increment[0], (got == 5));
            end
            got++;
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      n_cmp++; if (got !== 6) begin n_err++; $display("FAIL bp_count: got %0d want 6", got); end
      wait_idle();
   endtask

   task automatic test_stall_mid_skew();
      logic [3:0] tab [8];
      logic [31:0] d;
      tab = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
      d = 32'h44332211;
      for (int c = 0; c < 8; c++) begin
         in_valid = (c == 0);
         in_data  = d;
         in_last  = 1'b1;
         step();
         stall = (c == 2) || (c == 3);
         #1;
         n_cmp++; if (out_valid !== tab[c]) begin n_err++; $display("FAIL skew_valid c%0d: got %b want %b", c, out_valid, tab[c]); end
         n_cmp++; if (out_increment !== tab[c]) begin n_err++; $display("FAIL skew_inc c%0d: got %b want %b", c, out_increment, tab[c]); end
         for (int r = 0; r < 4; r++) begin
            if (tab[c][r]) begin
               n_cmp++;
               if (out_a[r*8 +: 8] !== d[r*8 +: 8]) begin
                  n_err++; $display("FAIL skew_data c%0d r%0d: got %h want %h", c, r, out_a[r*8 +: 8], d[r*8 +: 8]);
               end
            end
         end
      end
      in_valid = 1'b0; in_last = 1'b0; stall = 1'b0;
      wait_idle();
   endtask

   task automatic test_two_groups();
      logic [7:0] bt [4];
      logic       tv [10];
      logic [7:0] td [10];
      int gap, seen;
      bt = '{8'hA1, 8'hA2, 8'hB1, 8'hB2};
      tv = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      td = '{8'h00, 8'hA1, 8'hA2, 8'h00, 8'h00, 8'h00, 8'hB1, 8'hB2, 8'h00, 8'h00};
      gap = 0; seen = 0;
      for (int c = 0; c < 10; c++) begin
         in_valid = (c < 4);
         in_data  = (c < 4) ? {4{bt[c]}} : 32'h0;
         in_last  = (c == 1) || (c == 3);
         step();
         #1;
         n_cmp++; if (out_valid[0] !== tv[c]) begin n_err++; $display("FAIL groups_valid c%0d: got %b want %b", c, out_valid[0], tv[c]); end
         n_cmp++;
         if (out_increment[0] !== ((c == 2) || (c == 7))) begin
            n_err++; $display("FAIL groups_inc c%0d: got %b want %b", c, out_increment[0], ((c == 2) || (c == 7)));
         end
         if (tv[c]) begin
            n_cmp++; if (out_a[7:0] !== td[c]) begin n_err++; $display("FAIL groups_data c%0d: got %h want %h", c, out_a[7:0], td[c]); end
         end
         if (out_valid[0]) seen++;
         else if (seen == 2) gap++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      n_cmp++; if (gap !== 3) begin n_err++; $display("FAIL groups_gap: got %0d want 3", gap); end
      wait_idle();
   endtask

   task automatic test_reset_in_drain();
      logic [31:0] d;
      in_valid = 1'b1; in_data = 32'h0D0C0B0A; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      step();
      #1;
      n_cmp++; if (dut.state_q !== DRAIN) begin n_err++; $display("FAIL rd_pre_state: got %0d want %0d", dut.state_q, DRAIN); end
      n_cmp++; if (out_valid !== 4'b0001) begin n_err++; $display("FAIL rd_pre_valid: got %b want 0001", out_valid); end
      res_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 4'b0) begin n_err++; $display("FAIL rd_valid: got %b want 0000", out_valid); end
      n_cmp++; if (out_increment !== 4'b0) begin n_err++; $display("FAIL rd_inc: got %b want 0000", out_increment); end
      n_cmp++; if (out_a !== 32'h0) begin n_err++; $display("FAIL rd_out_a: got %h want 0", out_a); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rd_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL rd_busy: got %b want 0", out_busy); end
      step();
      step();
      res_n = 1'b1;
      step();
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready_after: got %b want 1", in_ready); end
      d = 32'h5A4B3C2D;
      in_valid = 1'b1; in_data = d; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         step();
         #1;
         n_cmp++;
         if (out_valid !== 4'(1 << (c - 1))) begin
            n_err++; $display("FAIL rd_new_valid c%0d: got %b want %b", c, out_valid, 4'(1 << (c - 1)));
         end
         n_cmp++;
         if (out_a[(c-1)*8 +: 8] !== d[(c-1)*8 +: 8]) begin
            n_err++; $display("FAIL rd_new_data c%0d: got %h want %h", c, out_a[(c-1)*8 +: 8], d[(c-1)*8 +: 8]);
         end
      end
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_stall_mid_skew();
      test_two_groups();
      test_reset_in_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
